// File: rtl/dff_arb_pkg.sv
// rtl/dff_arb_pkg.sv - shared FSM state encoding and HOLD counter width
// Contents:
//   state_t : IDLE=0, GRANT=1, HOLD=2
//   CNT_W   : width of the HOLD guard counter (HOLD_CYCLES 0..15)
package dff_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/dff_reg.sv
// rtl/dff_reg.sv - load-enabled D flip-flop bank with sync active-low reset
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset, loads RESET_VAL (wins over load)
//   load : capture d at the next edge
//   d    : WIDTH-bit input data
//   q    : WIDTH-bit registered contents
module dff_reg
   import dff_arb_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - two-requester arbiter writing a shared register
// Optional feature macro: DFF_ARB_RR_EN (round-robin; default fixed priority, req 0 wins)
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset
//   req   : [1:0] per-requester write request
//   data0 : write data from requester 0
//   data1 : write data from requester 1
//   gnt   : [1:0] registered one-hot grant
//   done  : one-cycle pulse in the cycle after Q is written
//   busy  : high whenever the FSM is not IDLE
//   Q     : shared register contents
module dff_bank_arbiter
   import dff_arb_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               HOLD_CYCLES = 2,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic [1:0]       gnt,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] Q
);

   // Counter is preloaded with HOLD_CYCLES-1 and counts down to 0, so HOLD
   // lasts exactly HOLD_CYCLES cycles.
   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic             pick;
   logic             load;
   logic [WIDTH-1:0] wdata;

   // While in GRANT, gnt itself records the winner, so it drives both the
   // completion test and the write-data mux.
   assign load  = (state == GRANT) && ((req & gnt) != 2'b00);
   assign wdata = gnt[1] ? data1 : data0;
   assign busy  = (state != IDLE);

`ifdef DFF_ARB_RR_EN
   logic rr_ptr;

   // rr_ptr names the requester favoured on a tie; only completed writes move it.
   assign pick = req[0] ? (req[1] & rr_ptr) : 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr <= 1'b0;
      end else if (load) begin
         rr_ptr <= ~gnt[1];
      end
   end
`else
   assign pick = ~req[0];
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         gnt      <= 2'b00;
         done     <= 1'b0;
         hold_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  gnt   <= pick ? 2'b10 : 2'b01;
                  state <= GRANT;
               end
            end
            GRANT: begin
               gnt <= 2'b00;
               if (load) begin
                  done <= 1'b1;
                  if (HOLD_CYCLES == 0) begin
                     state <= IDLE;
                  end else begin
                     state    <= HOLD;
                     hold_cnt <= HOLD_LAST;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 2'b00;
            end
         endcase
      end
   end

   dff_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_reg (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .d    (wdata),
      .q    (Q)
   );

endmodule

// File: doc/dff_bank_arbiter.md
DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the shared register and both data inputs.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, guard cycles after each write before the next grant; legal range 0..15.
REQ-003 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into Q on reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port req  input  2  per-requester write request, bit i for requester i.
REQ-007 SHALL have port data0  input  WIDTH  write data from requester 0.
REQ-008 SHALL have port data1  input  WIDTH  write data from requester 1.
REQ-009 SHALL have port gnt  output  2  registered one-hot grant; at most one bit high.
REQ-010 SHALL have port done  output  1  one-cycle pulse, high in the cycle after Q is updated.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port Q  output  WIDTH  shared register contents.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, HOLD.
REQ-014 IDLE: if any req bit is high at a clk edge, SHALL select a winner, set gnt to the winner's one-hot value and enter GRANT at that edge.
REQ-015 GRANT: if req[winner] is still high at the next edge, SHALL load Q with that requester's data, clear gnt and pulse done. SHALL then enter HOLD, or IDLE when HOLD_CYCLES=0.
REQ-016 GRANT: if req[winner] is low at the next edge (abort), SHALL leave Q unchanged, clear gnt, keep done low and return to IDLE with no HOLD.
REQ-017 HOLD: SHALL stay exactly HOLD_CYCLES cycles, ignore req, keep gnt=0, then enter IDLE.
REQ-018 Write latency from req sampled in IDLE to Q updated SHALL be 2 edges; done SHALL be high during the cycle after the second edge.
REQ-019 Requesters SHALL hold req and data stable from assertion until gnt is seen high; data SHALL be sampled only at the GRANT edge.
REQ-020 The non-winning requester's req SHALL stay pending, without loss, until it is granted.
REQ-021 Q SHALL change only at a completed GRANT edge or on reset.

Reset
REQ-022 When rst=0 at a clk edge: state=IDLE, gnt=2'b00, done=0, busy=0, Q=RESET_VAL, round-robin pointer favours requester 0.
REQ-023 Reset asserted in GRANT or HOLD SHALL abort the operation with no write, and no done pulse SHALL follow.

Configuration
REQ-024 With macro DFF_ARB_RR_EN defined, arbitration SHALL be round-robin: after a completed write by requester i, requester 1-i wins the next simultaneous request; an aborted grant SHALL NOT move the pointer.
REQ-025 Without DFF_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 always winning, and the pointer flop SHALL be absent.

Structure
REQ-026 State encoding (IDLE=0, GRANT=1, HOLD=2) and the HOLD counter width constant (4 bits) SHALL live in shared package dff_arb_pkg.
REQ-027 The register SHALL be a sub-module dff_reg: rising-edge D flip-flop bank with synchronous active-low reset to RESET_VAL and a load enable.
REQ-028 The FSM, arbiter, HOLD counter and write-data mux SHALL live in dff_bank_arbiter.

Verification
REQ-029 Reset: hold rst=0 for 5 cycles with req=2'b11 -> gnt=0, done=0, busy=0, Q=RESET_VAL throughout.
REQ-030 Single write: req=01, data0=8'hA5 -> gnt=01 after edge 1; Q=8'hA5 and done=1 after edge 2; busy stays high for 2 HOLD cycles, then IDLE.
REQ-031 Contention: req=11 held, data0=8'h11, data1=8'h22 -> with DFF_ARB_RR_EN, Q sequence 11, 22, 11; without it, Q=11 repeatedly and gnt[1] never asserts.
REQ-032 Abort: req=10, then drop req[1] while gnt=10 -> Q unchanged, done stays 0, IDLE on the next edge.
REQ-033 Reset mid-operation: rst=0 while in GRANT with req=01 -> Q=RESET_VAL, no done pulse, gnt=0 on the next edge.
REQ-034 HOLD_CYCLES=0, req=01 held continuously -> a write completes every 2 cycles and done pulses every other cycle.
